// File: rtl/tx_resp_scheduler.sv
// tx_resp_scheduler: buffers RF/ALU responses and feeds them byte-wise into the TX FIFO write port.
// Optional RESP_TAG_EN prefixes each response with a tag byte (0xB0 RF, 0xC0 ALU).
module tx_resp_scheduler #(
  parameter int DATA_WIDTH    = 8,
  parameter int ALU_OUT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_Valid,
  input  logic                     FIFO_FULL,
  output logic [DATA_WIDTH-1:0]    WR_DATA,
  output logic                     WR_INC,
  output logic                     BUSY,
  output logic                     OVERRUN
);
`ifdef RESP_TAG_EN
  typedef enum logic [2:0] {IDLE, SEND_RF, SEND_ALU_LO, SEND_ALU_HI, SEND_TAG} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND_RF, SEND_ALU_LO, SEND_ALU_HI} state_t;
`endif
  state_t state, cur, nxt;
  logic [DATA_WIDTH-1:0]    rf_hold, wr_byte;
  logic [ALU_OUT_WIDTH-1:0] alu_hold;
  logic rf_pend, alu_pend, rf_clr, alu_clr, launch;
  // IDLE arbitrates combinationally on registered pend bits, so a pending response
  // launches in the same cycle the FSM sees it (no idle bubble, one-cycle latency).
  always_comb begin
`ifdef RESP_TAG_EN
    cur = (state == IDLE) ? ((rf_pend | alu_pend) ? SEND_TAG : IDLE) : state;
`else
    cur = (state == IDLE) ? (rf_pend ? SEND_RF : alu_pend ? SEND_ALU_LO : IDLE) : state;
`endif
    launch  = (cur != IDLE) && !FIFO_FULL;
    wr_byte = '0;
    nxt     = IDLE;
    rf_clr  = 1'b0;
    alu_clr = 1'b0;
    case (cur)
      SEND_RF: begin
        wr_byte = rf_hold;
        rf_clr  = launch;
      end
      SEND_ALU_LO: begin
        wr_byte = alu_hold[DATA_WIDTH-1:0];
        nxt     = SEND_ALU_HI;
      end
      SEND_ALU_HI: begin
        wr_byte = alu_hold[ALU_OUT_WIDTH-1:DATA_WIDTH];
        alu_clr = launch;
      end
`ifdef RESP_TAG_EN
      SEND_TAG: begin
        wr_byte = rf_pend ? DATA_WIDTH'(8'hB0) : DATA_WIDTH'(8'hC0);
        nxt     = rf_pend ? SEND_RF : SEND_ALU_LO;
      end
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      rf_hold  <= '0;
      alu_hold <= '0;
      rf_pend  <= 1'b0;
      alu_pend <= 1'b0;
      WR_DATA  <= '0;
      WR_INC   <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      state    <= launch ? nxt : cur;
      rf_pend  <= RdData_Valid | (rf_pend & ~rf_clr);
      alu_pend <= OUT_Valid | (alu_pend & ~alu_clr);
      if (RdData_Valid && (!rf_pend || rf_clr)) rf_hold <= RdData;
      if (OUT_Valid && (!alu_pend || alu_clr)) alu_hold <= ALU_OUT;
      OVERRUN  <= OVERRUN | (RdData_Valid & rf_pend & ~rf_clr) | (OUT_Valid & alu_pend & ~alu_clr);
      WR_INC   <= launch;
      if (launch) WR_DATA <= wr_byte;
    end
  end
  assign BUSY = rf_pend | alu_pend | (state != IDLE);
endmodule

// File: tb/tb_tx_resp_scheduler.sv
// tb_tx_resp_scheduler: cycle table for the base build plus directed multi-cycle sequences.
module tb_tx_resp_scheduler;
  logic clk = 0, rst_n = 0;
  logic [7:0] rd_data = 0, wr_data;
  logic [15:0] alu_out = 0;
  logic rd_valid = 0, out_valid = 0, fifo_full = 0, wr_inc, busy, overrun;
  logic [7:0] q[$];
  int tests = 0, fails = 0;

  tx_resp_scheduler dut (
    .CLK(clk), .RST(rst_n), .RdData(rd_data), .RdData_Valid(rd_valid),
    .ALU_OUT(alu_out), .OUT_Valid(out_valid), .FIFO_FULL(fifo_full),
    .WR_DATA(wr_data), .WR_INC(wr_inc), .BUSY(busy), .OVERRUN(overrun)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && wr_inc) q.push_back(wr_data);

  typedef struct {
    logic rv; logic [7:0] rd; logic av; logic [15:0] alu; logic full;
    logic inc; logic [7:0] data; logic busy; logic ovr;
  } vec_t;
  vec_t v[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; rd_valid = 0; out_valid = 0; fifo_full = 0;
    @(negedge clk);
    rst_n = 1;
    q.delete();
  endtask

  task automatic strobe(input logic rv, input logic [7:0] rd, input logic av, input logic [15:0] alu);
    @(negedge clk);
    rd_valid = rv; rd_data = rd; out_valid = av; alu_out = alu;
    @(negedge clk);
    rd_valid = 0; out_valid = 0;
  endtask

  task automatic check_seq(input string name, input int n, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    chk({name, "_count"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) chk({name, "_byte"}, q[i], e[i]);
  endtask

  initial begin
    v[0]  = '{0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 0, 0};
    v[1]  = '{1, 8'h09, 0, 16'h0000, 0, 0, 8'h00, 1, 0};
    v[2]  = '{0, 8'h00, 0, 16'h0000, 0, 1, 8'h09, 0, 0};
    v[3]  = '{0, 8'h00, 0, 16'h0000, 0, 0, 8'h09, 0, 0};
    v[4]  = '{0, 8'h00, 1, 16'h0BB8, 0, 0, 8'h09, 1, 0};
    v[5]  = '{0, 8'h00, 0, 16'h0000, 0, 1, 8'hB8, 1, 0};
    v[6]  = '{0, 8'h00, 0, 16'h0000, 0, 1, 8'h0B, 0, 0};
    v[7]  = '{1, 8'h5A, 1, 16'h0A0A, 0, 0, 8'h0B, 1, 0};
    v[8]  = '{0, 8'h00, 0, 16'h0000, 0, 1, 8'h5A, 1, 0};
    v[9]  = '{0, 8'h00, 0, 16'h0000, 0, 1, 8'h0A, 1, 0};
    v[10] = '{0, 8'h00, 0, 16'h0000, 0, 1, 8'h0A, 0, 0};
    v[11] = '{1, 8'h33, 0, 16'h0000, 1, 0, 8'h0A, 1, 0};
    v[12] = '{0, 8'h00, 0, 16'h0000, 1, 0, 8'h0A, 1, 0};
    v[13] = '{1, 8'h44, 0, 16'h0000, 0, 1, 8'h33, 1, 0};
    v[14] = '{0, 8'h00, 0, 16'h0000, 0, 1, 8'h44, 0, 0};
    v[15] = '{0, 8'h00, 1, 16'h3344, 0, 0, 8'h44, 1, 0};
    v[16] = '{0, 8'h00, 1, 16'h2222, 0, 1, 8'h44, 1, 1};
    v[17] = '{0, 8'h00, 0, 16'h0000, 0, 1, 8'h33, 0, 1};
    v[18] = '{0, 8'h00, 0, 16'h0000, 0, 0, 8'h33, 0, 1};
    #1;
    chk("reset_wr_inc", wr_inc, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    do_reset();
`ifndef RESP_TAG_EN
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rd_valid = v[i].rv; rd_data = v[i].rd; out_valid = v[i].av; alu_out = v[i].alu; fifo_full = v[i].full;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_wr_inc", i), wr_inc, v[i].inc);
      chk($sformatf("vec%0d_wr_data", i), wr_data, v[i].data);
      chk($sformatf("vec%0d_busy", i), busy, v[i].busy);
      chk($sformatf("vec%0d_overrun", i), overrun, v[i].ovr);
    end
    @(negedge clk);
    rd_valid = 0; out_valid = 0; fifo_full = 0;
`endif
    // basic single responses
    do_reset();
    strobe(1, 8'h09, 0, 16'h0);
    repeat (4) @(negedge clk);
    chk("rf_busy_done", busy, 0);
`ifdef RESP_TAG_EN
    check_seq("rf_single", 2, 8'hB0, 8'h09, 8'h00);
`else
    check_seq("rf_single", 1, 8'h09, 8'h00, 8'h00);
`endif
    q.delete();
    strobe(0, 8'h0, 1, 16'h0BB8);
    repeat (5) @(negedge clk);
`ifdef RESP_TAG_EN
    check_seq("alu_single", 3, 8'hC0, 8'hB8, 8'h0B);
`else
    check_seq("alu_single", 2, 8'hB8, 8'h0B, 8'h00);
`endif
    q.delete();
    strobe(1, 8'h5A, 1, 16'h0A0A);
    repeat (8) @(negedge clk);
    chk("both_overrun", overrun, 0);
`ifdef RESP_TAG_EN
    chk("both_count", q.size(), 5);
`else
    check_seq("both", 3, 8'h5A, 8'h0A, 8'h0A);
`endif
    // ALU pair held off by a full FIFO
    do_reset();
    fifo_full = 1;
    strobe(0, 8'h0, 1, 16'h1234);
    repeat (9) @(negedge clk);
    chk("stall_no_write", q.size(), 0);
    chk("stall_busy", busy, 1);
    fifo_full = 0;
    repeat (6) @(negedge clk);
`ifdef RESP_TAG_EN
    check_seq("stall_alu", 3, 8'hC0, 8'h34, 8'h12);
`else
    check_seq("stall_alu", 2, 8'h34, 8'h12, 8'h00);
`endif
    // second RF strobe while first is stuck
    do_reset();
    fifo_full = 1;
    strobe(1, 8'h11, 0, 16'h0);
    strobe(1, 8'h22, 0, 16'h0);
    chk("ovr_set", overrun, 1);
    fifo_full = 0;
    repeat (6) @(negedge clk);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_idle", busy, 0);
`ifdef RESP_TAG_EN
    check_seq("ovr_data", 2, 8'hB0, 8'h11, 8'h00);
`else
    check_seq("ovr_data", 1, 8'h11, 8'h00, 8'h00);
`endif
    // asynchronous reset in the middle of an ALU pair
    do_reset();
    strobe(0, 8'h0, 1, 16'hABCD);
    @(posedge clk);
    #2;
    chk("mid_pair_inc", wr_inc, 1);
`ifdef RESP_TAG_EN
    chk("mid_pair_data", wr_data, 8'hC0);
`else
    chk("mid_pair_data", wr_data, 8'hCD);
`endif
    rst_n = 0;
    #1;
    chk("async_rst_inc", wr_inc, 0);
    chk("async_rst_data", wr_data, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    q.delete();
    repeat (10) @(negedge clk);
    chk("no_residual", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
